// File: rtl/adc_avg_pkg.sv
// Shared types, default parameters and width helpers for the multi-channel ADC block averager.
// Optional ADC_AVG_ROUND_EN macro selects round-half-up with saturation in adc_avg_acc_ch.
package adc_avg_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  localparam int unsigned DEF_ADC_WIDTH  = 12;
  localparam int unsigned DEF_NUM_CH     = 4;
  localparam int unsigned DEF_MAX_LOG2_N = 10;

  // Accumulator holds 2^max_l samples of adc_w bits without overflow.
  function automatic int unsigned acc_w(input int unsigned adc_w, input int unsigned max_l);
    return adc_w + max_l;
  endfunction

  function automatic int unsigned log2_w(input int unsigned max_l);
    return $clog2(max_l + 1);
  endfunction

  // Sample counter must reach 2^max_l - 1.
  function automatic int unsigned cnt_w(input int unsigned max_l);
    return max_l + 1;
  endfunction

endpackage

// File: rtl/adc_avg_acc_ch.sv
// One channel: signed accumulator plus arithmetic-shift mean register.
// With ADC_AVG_ROUND_EN defined the mean is rounded half-up and saturated; otherwise it is floored.
module adc_avg_acc_ch
  import adc_avg_pkg::*;
#(
  parameter int unsigned ADC_WIDTH  = DEF_ADC_WIDTH,
  parameter int unsigned MAX_LOG2_N = DEF_MAX_LOG2_N
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_clr,
  input  logic                              i_add,
  input  logic                              i_done,
  input  logic [ADC_WIDTH-1:0]              i_sample,
  input  logic [log2_w(MAX_LOG2_N)-1:0]     i_l_q,
  output logic [ADC_WIDTH-1:0]              o_mean
);

  localparam int unsigned ACC_W = acc_w(ADC_WIDTH, MAX_LOG2_N);
  localparam int unsigned LW    = log2_w(MAX_LOG2_N);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_sum;
  logic [ADC_WIDTH-1:0]    w_mean;
  logic [ADC_WIDTH-1:0]    r_mean;

  // The window's last sample is folded in combinationally so the result lands on the same edge.
  assign w_sum = r_acc + ACC_W'($signed(i_sample));

`ifdef ADC_AVG_ROUND_EN
  localparam logic signed [ACC_W-1:0] MAX_POS = ACC_W'((1 << (ADC_WIDTH - 1)) - 1);

  logic signed [ACC_W-1:0] w_rnd;
  logic signed [ACC_W-1:0] w_shift;

  assign w_rnd   = (i_l_q == '0) ? '0 : (ACC_W'(1) << (i_l_q - LW'(1)));
  assign w_shift = (w_sum + w_rnd) >>> i_l_q;
  assign w_mean  = (w_shift > MAX_POS) ? ADC_WIDTH'(MAX_POS) : ADC_WIDTH'(w_shift);
`else
  assign w_mean  = ADC_WIDTH'(w_sum >>> i_l_q);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc  <= '0;
      r_mean <= '0;
    end else if (i_clr) begin
      r_acc  <= '0;
    end else if (i_done) begin
      r_acc  <= '0;
      r_mean <= w_mean;
    end else if (i_add) begin
      r_acc  <= w_sum;
    end
  end

  assign o_mean = r_mean;

endmodule

// File: rtl/adc_avg_multi.sv
// Multi-channel ADC block averager: back-to-back windows of 2^LOG2_N samples, strobed per-channel mean.
// Build option ADC_AVG_ROUND_EN switches the channels from floor to round-half-up with saturation.
module adc_avg_multi
  import adc_avg_pkg::*;
#(
  parameter int unsigned ADC_WIDTH  = DEF_ADC_WIDTH,
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned MAX_LOG2_N = DEF_MAX_LOG2_N
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_en,
  input  logic [log2_w(MAX_LOG2_N)-1:0] i_log2_n,
  input  logic                          i_in_valid,
  input  logic [NUM_CH*ADC_WIDTH-1:0]   i_data_in,
  output logic                          o_out_valid,
  output logic [NUM_CH*ADC_WIDTH-1:0]   o_data_out,
  output logic                          o_busy
);

  localparam int unsigned LW = log2_w(MAX_LOG2_N);
  localparam int unsigned CW = cnt_w(MAX_LOG2_N);

  state_e          r_state;
  state_e          w_next_state;
  logic [LW-1:0]   r_l_q;
  logic [LW-1:0]   w_l_in;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_last;
  logic            r_out_valid;
  logic            r_busy;
  logic            w_win_end;
  logic            w_clr;
  logic            w_add;
  logic            w_done;
  logic            w_load_l;

  assign w_l_in    = (i_log2_n > LW'(MAX_LOG2_N)) ? LW'(MAX_LOG2_N) : i_log2_n;
  assign w_last    = (CW'(1) << r_l_q) - CW'(1);
  // Window end does not depend on EN so a result is still emitted when EN drops on that edge.
  assign w_win_end = (r_state == ACCUM) && i_in_valid && (r_cnt == w_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_en) w_next_state = ACCUM;
      ACCUM: begin
        if (w_win_end)  w_next_state = i_en ? ACCUM : IDLE;
        else if (!i_en) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_clr    = 1'b0;
    w_add    = 1'b0;
    w_done   = 1'b0;
    w_load_l = 1'b0;
    case (r_state)
      IDLE: begin
        w_clr    = 1'b1;
        w_load_l = i_en;
      end
      ACCUM: begin
        w_done   = w_win_end;
        w_load_l = w_win_end;
        w_add    = i_en && i_in_valid && !w_win_end;
      end
      default: w_clr = 1'b1;
    endcase
  end

  // Sample counter, latched window exponent and output strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_l_q       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_out_valid <= w_done;
      r_busy      <= (w_next_state == ACCUM);
      if (w_load_l)            r_l_q <= w_l_in;
      if (w_clr || w_done)     r_cnt <= '0;
      else if (w_add)          r_cnt <= r_cnt + CW'(1);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    adc_avg_acc_ch #(
      .ADC_WIDTH  (ADC_WIDTH),
      .MAX_LOG2_N (MAX_LOG2_N)
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clr    (w_clr),
      .i_add    (w_add),
      .i_done   (w_done),
      .i_sample (i_data_in[k*ADC_WIDTH +: ADC_WIDTH]),
      .i_l_q    (r_l_q),
      .o_mean   (o_data_out[k*ADC_WIDTH +: ADC_WIDTH])
    );
  end

  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_adc_avg_multi.sv
// Scoreboard bench for adc_avg_multi: directed windows push expected means, a negedge monitor pops and checks.
// Expectations follow ADC_AVG_ROUND_EN when the build defines it.
module tb_adc_avg_multi;
  import adc_avg_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned NC = 4;
  localparam int unsigned ML = 10;
  localparam int unsigned LW = 4;
`ifdef ADC_AVG_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef logic [NC*AW-1:0] vec_t;
  typedef struct {
    vec_t data;
    int   cyc;
    int   id;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [LW-1:0] log2_n;
  logic          in_valid;
  vec_t          din;
  logic          out_valid;
  vec_t          dout;
  logic          busy;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_avg_multi #(.ADC_WIDTH(AW), .NUM_CH(NC), .MAX_LOG2_N(ML)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_log2_n   (log2_n),
    .i_in_valid (in_valid),
    .i_data_in  (din),
    .o_out_valid(out_valid),
    .o_data_out (dout),
    .o_busy     (busy)
  );

  function automatic vec_t pk(input int a, input int b, input int c, input int d);
    vec_t v;
    v[0*AW +: AW] = AW'(a);
    v[1*AW +: AW] = AW'(b);
    v[2*AW +: AW] = AW'(c);
    v[3*AW +: AW] = AW'(d);
    return v;
  endfunction

  function automatic int sel(input int fl, input int rn);
    return RND ? rn : fl;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive(input logic v, input vec_t d);
    @(negedge clk);
    in_valid = v;
    din      = d;
  endtask

  // Result appears one cycle after the sample just driven.
  task automatic expect_out(input int id, input vec_t d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + 1;
    e.id   = id;
    sb.push_back(e);
  endtask

  task automatic restart(input logic [LW-1:0] l);
    @(negedge clk);
    en = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    en = 1'b1;
    log2_n = l;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got data %h at cycle %0d, expected no output", dout, cyc);
      end else begin
        e = sb.pop_front();
        if (dout !== e.data || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL result_%0d: got data %h cycle %0d, expected data %h cycle %0d",
                   e.id, dout, cyc, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1; en = 1'b0; in_valid = 1'b0; log2_n = '0; din = '0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_data_out", 64'(dout), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Gapped ramp, one valid cycle in three
    restart(LW'(2));
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, pk(i, -i, 5, 0));
      if (i == 4) expect_out(1, pk(sel(2, 3), sel(-3, -2), 5, 0));
      drive(1'b0, '0);
      drive(1'b0, '0);
    end

    // Floor versus round, plus full-scale values
    restart(LW'(1));
    drive(1'b1, pk(3, -3, 2047, -2048));
    drive(1'b1, pk(4, -4, 2047, -2048));
    expect_out(2, pk(sel(3, 4), sel(-4, -3), 2047, -2048));
    drive(1'b0, '0);

    // Async reset in the middle of a window
    restart(LW'(2));
    drive(1'b1, pk(1, 1, 1, 1));
    drive(1'b1, pk(1, 1, 1, 1));
    drive(1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_data_out", 64'(dout), 64'd0);
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, pk(10, -7, 0, 100));
    drive(1'b1, pk(20, -7, 0, 0));
    drive(1'b1, pk(30, -7, 0, 0));
    drive(1'b1, pk(40, -7, 0, 0));
    expect_out(3, pk(25, -7, 0, 25));
    drive(1'b0, '0);

    // Constant input, exponent 15 clamps to 10, two back-to-back windows
    restart(LW'(15));
    for (int i = 0; i < 2048; i++) begin
      drive(1'b1, pk(100, -100, 2047, -2048));
      if (i % 1024 == 1023) expect_out(4 + i / 1024, pk(100, -100, 2047, -2048));
    end
    drive(1'b0, '0);

    // Exponent change mid-window, then pass-through
    restart(LW'(3));
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, pk(i, -5, 0, (i == 1) ? 16 : 0));
      if (i == 3) log2_n = LW'(1);
    end
    expect_out(6, pk(sel(4, 5), -5, 0, 2));
    drive(1'b1, pk(10, -5, 0, 1));
    log2_n = LW'(0);
    drive(1'b1, pk(11, -5, 0, 0));
    expect_out(7, pk(sel(10, 11), -5, 0, sel(0, 1)));
    drive(1'b1, pk(7, -7, 2047, -2048));
    expect_out(8, pk(7, -7, 2047, -2048));
    drive(1'b1, pk(-1, 1, 0, 5));
    expect_out(9, pk(-1, 1, 0, 5));
    drive(1'b0, '0);
    drive(1'b1, pk(0, -2048, 1, -1));
    expect_out(10, pk(0, -2048, 1, -1));
    drive(1'b0, '0);

    // EN dropped after 5 of 8 samples; valid samples while idle are ignored
    restart(LW'(3));
    for (int i = 0; i < 5; i++) drive(1'b1, pk(1000, 1000, 1000, 1000));
    @(negedge clk);
    en = 1'b0;
    drive(1'b1, pk(500, 500, 500, 500));
    drive(1'b1, pk(500, 500, 500, 500));
    @(negedge clk);
    en = 1'b1;
    in_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, pk(i, -2048, 7, (i % 2 == 1) ? 1 : -1));
      if (i == 8) expect_out(11, pk(sel(4, 5), -2048, 7, 0));
    end
    drive(1'b0, '0);

    // EN falls on the window-end edge: result still emitted, then idle
    restart(LW'(1));
    drive(1'b1, pk(6, 0, 0, 0));
    drive(1'b1, pk(9, 0, 0, 0));
    en = 1'b0;
    expect_out(12, pk(sel(7, 8), 0, 0, 0));
    drive(1'b0, '0);
    check("busy_after_en_drop", 64'(busy), 64'd0);
    drive(1'b1, pk(1, 2, 3, 4));
    drive(1'b1, pk(1, 2, 3, 4));
    drive(1'b0, '0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
